cnn_layer_accel_weight_cfg_writer: RTL and testbench

- Configuration-side master of the weight-table config port.
- Accepts a job descriptor (kernel count) and a 16-bit weight stream with valid/ready handshake.
- Drives job_accept, config_mode, kernel_config_valid/kernel_full_count and wht_config_wren/data, so that each 3x3 kernel (9 words) lands in consecutive kernel groups.
- Issues a closing job_accept so kernel_group is rewound to 0 before execution.

---
 rtl/cnn_layer_accel_pkg.sv | 24 ++
 rtl/cnn_layer_accel_weight_cfg_writer.sv | 112 +++++++++++
 tb/tb_cnn_layer_accel_weight_cfg_writer.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cnn_layer_accel_pkg.sv
// Shared types and constants for the CNN layer accelerator
// weight-configuration path.
package cnn_layer_accel_pkg;

  localparam int C_KERNEL_WORDS = 9;
  localparam int C_WHT_WIDTH    = 16;
  localparam int C_MAX_KERNELS  = 64;

  typedef logic [C_WHT_WIDTH-1:0] wht_word_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_LOAD,
    S_GAP,
    S_HOLD,
    S_CLOSE
  } wcfg_state_t;

  function automatic logic kernels_legal(input logic [6:0] n);
    return (n != 7'd0) && (n <= 7'(C_MAX_KERNELS));
  endfunction

endpackage

// File: rtl/cnn_layer_accel_weight_cfg_writer.sv
// Weight-table config writer: streams 3x3 kernels into consecutive
// kernel groups, bracketed by job_accept rewind pulses.
module cnn_layer_accel_weight_cfg_writer
  import cnn_layer_accel_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        job_start,
  input  logic [6:0]  job_num_kernels,
  output logic        job_busy,
  output logic        job_done,
  output logic        job_err,
  input  logic        s_wht_valid,
  input  logic [15:0] s_wht_data,
  output logic        s_wht_ready,
  output logic        job_accept,
  output logic        config_mode,
  output logic        kernel_config_valid,
  output logic [15:0] kernel_full_count,
  output logic        wht_config_wren,
  output logic [15:0] wht_config_data
);

  localparam logic [3:0] LAST_WORD = 4'(C_KERNEL_WORDS - 1);

  wcfg_state_t state;
  logic [3:0]  word_cnt;
  logic [5:0]  kernel_cnt;
  logic [5:0]  n_m1;

  assign s_wht_ready = (state == S_LOAD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= S_IDLE;
      word_cnt            <= '0;
      kernel_cnt          <= '0;
      n_m1                <= '0;
      job_busy            <= 1'b0;
      job_done            <= 1'b0;
      job_err             <= 1'b0;
      job_accept          <= 1'b0;
      config_mode         <= 1'b0;
      kernel_config_valid <= 1'b0;
      kernel_full_count   <= '0;
      wht_config_wren     <= 1'b0;
      wht_config_data     <= '0;
    end else begin
      job_accept          <= 1'b0;
      job_done            <= 1'b0;
      job_err             <= 1'b0;
      kernel_config_valid <= 1'b0;
      wht_config_wren     <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (job_start) begin
            if (kernels_legal(job_num_kernels)) begin
              n_m1                <= 6'(job_num_kernels - 7'd1);
              kernel_full_count   <= {10'd0, 6'(job_num_kernels - 7'd1)};
              job_accept          <= 1'b1;
              kernel_config_valid <= 1'b1;
              config_mode         <= 1'b1;
              job_busy            <= 1'b1;
              state               <= S_ACCEPT;
            end else begin
              job_err <= 1'b1;
            end
          end
        end
        S_ACCEPT: begin
          word_cnt   <= '0;
          kernel_cnt <= '0;
          state      <= S_LOAD;
        end
        S_LOAD: begin
          if (s_wht_valid) begin
            wht_config_wren <= 1'b1;
            wht_config_data <= s_wht_data;
            if (word_cnt == LAST_WORD) begin
              state <= S_GAP;
            end else begin
              word_cnt <= word_cnt + 4'd1;
            end
          end
        end
        // Ready drops here so no write lands while the table
        // sits at its kernel_count wrap.
        S_GAP: begin
          if (kernel_cnt != n_m1) begin
            kernel_cnt <= kernel_cnt + 6'd1;
            word_cnt   <= '0;
            state      <= S_LOAD;
          end else begin
            state <= S_HOLD;
          end
        end
        S_HOLD: begin
          job_accept  <= 1'b1;
          job_done    <= 1'b1;
          config_mode <= 1'b0;
          state       <= S_CLOSE;
        end
        S_CLOSE: begin
          job_busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_layer_accel_weight_cfg_writer.sv
// Directed bench for the weight-table config writer.
// Cycle 0 is the cycle job_start is presented.
module tb_cnn_layer_accel_weight_cfg_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        job_start;
  logic [6:0]  job_num_kernels;
  logic        job_busy;
  logic        job_done;
  logic        job_err;
  logic        s_wht_valid;
  logic [15:0] s_wht_data;
  logic        s_wht_ready;
  logic        job_accept;
  logic        config_mode;
  logic        kernel_config_valid;
  logic [15:0] kernel_full_count;
  logic        wht_config_wren;
  logic [15:0] wht_config_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cnn_layer_accel_weight_cfg_writer dut (
    .clk                 (clk),
    .rst                 (rst),
    .job_start           (job_start),
    .job_num_kernels     (job_num_kernels),
    .job_busy            (job_busy),
    .job_done            (job_done),
    .job_err             (job_err),
    .s_wht_valid         (s_wht_valid),
    .s_wht_data          (s_wht_data),
    .s_wht_ready         (s_wht_ready),
    .job_accept          (job_accept),
    .config_mode         (config_mode),
    .kernel_config_valid (kernel_config_valid),
    .kernel_full_count   (kernel_full_count),
    .wht_config_wren     (wht_config_wren),
    .wht_config_data     (wht_config_data)
  );

  function automatic logic [15:0] word(input int i);
    return 16'(32'hC35A ^ (i * 32'h0107));
  endfunction

  function automatic logic [7:0] ctl_now();
    return {s_wht_ready, wht_config_wren, job_accept, job_done,
            kernel_config_valid, config_mode, job_busy, job_err};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    job_start = 1'b0;
    job_num_kernels = 7'd0;
    s_wht_valid = 1'b0;
    s_wht_data = 16'h0;
    tick();
    tick();
    tests++;
    if (ctl_now() !== 8'h00) begin
      fails++;
      $display("FAIL reset_ctl: got %b want %b", ctl_now(), 8'h00);
    end
    tests++;
    if ({kernel_full_count, wht_config_data} !== 32'h0) begin
      fails++;
      $display("FAIL reset_data: got %h/%h want 0/0",
               kernel_full_count, wht_config_data);
    end
    rst = 1'b0;
    tick();
  endtask

  // ctl bits: ready wren accept done kcv cfg busy err
  task automatic test_single_kernel();
    int idx;
    logic hs;
    logic [7:0] exp;
    idx = 0;
    job_num_kernels = 7'd1;
    job_start = 1'b1;
    s_wht_valid = 1'b1;
    s_wht_data = word(0);
    for (int c = 1; c <= 15; c++) begin
      hs = s_wht_valid && s_wht_ready;
      tick();
      job_start = 1'b0;
      if (hs) idx++;
      exp = {(c >= 2 && c <= 10), (c >= 3 && c <= 11),
             (c == 1 || c == 13), (c == 13), (c == 1),
             (c >= 1 && c <= 12), (c >= 1 && c <= 13), 1'b0};
      tests++;
      if (ctl_now() !== exp) begin
        fails++;
        $display("FAIL n1_ctl c=%0d: got %b want %b", c, ctl_now(), exp);
      end
      if (c >= 3 && c <= 11) begin
        tests++;
        if (wht_config_data !== word(c - 3)) begin
          fails++;
          $display("FAIL n1_data c=%0d: got %h want %h",
                   c, wht_config_data, word(c - 3));
        end
      end
      if (c == 1) begin
        tests++;
        if (kernel_full_count !== 16'd0) begin
          fails++;
          $display("FAIL n1_kfc: got %h want 0000", kernel_full_count);
        end
      end
      s_wht_data = word(idx);
    end
    s_wht_valid = 1'b0;
  endtask

  task automatic test_two_kernels();
    int idx;
    int di;
    logic hs;
    logic [7:0] exp;
    idx = 0;
    job_num_kernels = 7'd2;
    job_start = 1'b1;
    s_wht_valid = 1'b1;
    s_wht_data = word(0);
    for (int c = 1; c <= 25; c++) begin
      hs = s_wht_valid && s_wht_ready;
      tick();
      job_start = 1'b0;
      if (hs) idx++;
      exp = {(c >= 2 && c <= 20 && c != 11),
             (c >= 3 && c <= 21 && c != 12),
             (c == 1 || c == 23), (c == 23), (c == 1),
             (c >= 1 && c <= 22), (c >= 1 && c <= 23), 1'b0};
      tests++;
      if (ctl_now() !== exp) begin
        fails++;
        $display("FAIL n2_ctl c=%0d: got %b want %b", c, ctl_now(), exp);
      end
      if (exp[6]) begin
        di = (c <= 11) ? c - 3 : c - 4;
        tests++;
        if (wht_config_data !== word(di)) begin
          fails++;
          $display("FAIL n2_data c=%0d: got %h want %h",
                   c, wht_config_data, word(di));
        end
      end
      if (c == 1 || c == 23) begin
        tests++;
        if (kernel_full_count !== 16'd1) begin
          fails++;
          $display("FAIL n2_kfc c=%0d: got %h want 0001",
                   c, kernel_full_count);
        end
      end
      // mid-job start request must be ignored
      job_start = (c == 4);
      job_num_kernels = (c == 4) ? 7'd3 : 7'd2;
      s_wht_data = word(idx);
    end
    s_wht_valid = 1'b0;
  endtask

  task automatic test_long_job_stalls();
    int idx;
    int nwren;
    bit done_seen;
    bit after_gap;
    logic hs;
    idx = 0;
    nwren = 0;
    done_seen = 1'b0;
    after_gap = 1'b0;
    job_num_kernels = 7'd64;
    job_start = 1'b1;
    s_wht_valid = 1'b0;
    s_wht_data = word(0);
    for (int c = 1; c <= 3000 && !done_seen; c++) begin
      hs = s_wht_valid && s_wht_ready;
      tick();
      job_start = 1'b0;
      if (hs) idx++;
      if (c == 1) begin
        tests++;
        if (kernel_full_count !== 16'd63 || job_accept !== 1'b1) begin
          fails++;
          $display("FAIL n64_accept: got kfc=%h acc=%b want 003f/1",
                   kernel_full_count, job_accept);
        end
      end
      tests++;
      if (wht_config_wren !== hs) begin
        fails++;
        $display("FAIL n64_wren c=%0d: got %b want %b",
                 c, wht_config_wren, hs);
      end
      if (wht_config_wren) begin
        tests++;
        if (wht_config_data !== word(nwren)) begin
          fails++;
          $display("FAIL n64_data w=%0d: got %h want %h",
                   nwren, wht_config_data, word(nwren));
        end
        nwren++;
      end
      if (after_gap && idx < 576) begin
        tests++;
        if (s_wht_ready !== 1'b1) begin
          fails++;
          $display("FAIL n64_reload c=%0d: got %b want 1", c, s_wht_ready);
        end
      end
      after_gap = 1'b0;
      if (hs && (idx % 9) == 0) begin
        after_gap = 1'b1;
        tests++;
        if (s_wht_ready !== 1'b0) begin
          fails++;
          $display("FAIL n64_gap c=%0d: got %b want 0", c, s_wht_ready);
        end
      end
      if (job_done) begin
        done_seen = 1'b1;
        tests++;
        if (nwren !== 576 || job_accept !== 1'b1 || config_mode !== 1'b0) begin
          fails++;
          $display("FAIL n64_done: got wrens=%0d acc=%b cfg=%b want 576/1/0",
                   nwren, job_accept, config_mode);
        end
      end
      s_wht_valid = ($urandom_range(0, 9) >= 3);
      s_wht_data = word(idx);
    end
    s_wht_valid = 1'b0;
    tests++;
    if (!done_seen) begin
      fails++;
      $display("FAIL n64_timeout: got done=0 want done=1 (wrens=%0d)", nwren);
    end
    tick();
    tick();
  endtask

  task automatic test_bad_count();
    logic [6:0] bad [3];
    bad = '{7'd0, 7'd65, 7'd127};
    for (int i = 0; i < 3; i++) begin
      job_num_kernels = bad[i];
      job_start = 1'b1;
      tick();
      job_start = 1'b0;
      tests++;
      if (ctl_now() !== 8'b0000_0001) begin
        fails++;
        $display("FAIL bad%0d_err: got %b want 00000001",
                 bad[i], ctl_now());
      end
      tick();
      tests++;
      if (ctl_now() !== 8'h00) begin
        fails++;
        $display("FAIL bad%0d_after: got %b want 00000000",
                 bad[i], ctl_now());
      end
    end
  endtask

  task automatic test_reset_mid_job();
    int idx;
    logic hs;
    idx = 0;
    job_num_kernels = 7'd5;
    job_start = 1'b1;
    s_wht_valid = 1'b1;
    s_wht_data = word(0);
    for (int c = 1; c <= 25; c++) begin
      hs = s_wht_valid && s_wht_ready;
      tick();
      job_start = 1'b0;
      if (hs) idx++;
      s_wht_data = word(idx);
    end
    tests++;
    if ({job_busy, wht_config_wren, s_wht_ready} !== 3'b111) begin
      fails++;
      $display("FAIL rst_pre: got %b want 111",
               {job_busy, wht_config_wren, s_wht_ready});
    end
    rst = 1'b1;
    tick();
    tests++;
    if (ctl_now() !== 8'h00) begin
      fails++;
      $display("FAIL rst_mid_ctl: got %b want 00000000", ctl_now());
    end
    tests++;
    if ({kernel_full_count, wht_config_data} !== 32'h0) begin
      fails++;
      $display("FAIL rst_mid_data: got %h/%h want 0/0",
               kernel_full_count, wht_config_data);
    end
    rst = 1'b0;
    s_wht_valid = 1'b0;
    tick();
    tests++;
    if (ctl_now() !== 8'h00) begin
      fails++;
      $display("FAIL rst_idle: got %b want 00000000", ctl_now());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_kernel();
    test_two_kernels();
    test_long_job_stalls();
    test_bad_count();
    test_reset_mid_job();
    test_single_kernel();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
